// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 per-session sequencing controller.
// Classifies each parsed packet as forward / partial-skip / drop, tracks the
// next expected sequence number and raises retransmission requests on gaps.
//
// state   | meaning
// --------+------------------------------------------------------------
// INIT    | no session locked yet; first header latches the session id
// IDLE    | locked, waiting for the next header
// FWD     | packet in order (or overlapping); forward once skip_q == 0
// DROP    | packet discarded until pkt_end_i
// END     | end-of-session seen; absorbing until reset
module mold_seq_ctrl #(
  parameter int              SID_W    = 80,
  parameter int              SEQ_W    = 64,
  parameter int              ML_W     = 16,
  parameter logic [ML_W-1:0] RETX_MAX = 16'd256
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             hdr_v_i,
  input  logic [SID_W-1:0] hdr_sid_i,
  input  logic [SEQ_W-1:0] hdr_seq_i,
  input  logic [ML_W-1:0]  hdr_cnt_i,
  input  logic             msg_end_i,
  input  logic             pkt_end_i,
  output logic             fwd_o,
  output logic             drop_o,
  output logic             retx_v_o,
  output logic [SEQ_W-1:0] retx_seq_o,
  output logic [ML_W-1:0]  retx_cnt_o,
  input  logic             retx_ready_i,
  output logic [SEQ_W-1:0] expect_seq_o,
  output logic             locked_o,
  output logic             eos_o,
  output logic             proto_err_o
);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_FWD, ST_DROP, ST_END} state_t;

  state_t            state_q, state_d;
  logic [SID_W-1:0]  sid_q;
  logic [SEQ_W-1:0]  exp_q, seq_q, retx_seq_q;
  logic [ML_W-1:0]   cnt_q, skip_q, retx_cnt_q;
  logic              locked_q, drop_q, perr_q, eos_q, retx_v_q;

  logic              cls_drop, cls_gap;
  logic [SEQ_W-1:0]  e_eff, gap_dist;
  logic [SEQ_W:0]    seq_sum;
  logic [ML_W-1:0]   skip_init, retx_len;
  logic              sid_ok, retx_fire;

  // In INIT the header itself defines E, so it always resolves in-order.
  assign e_eff     = (state_q == ST_INIT) ? hdr_seq_i : exp_q;
  assign sid_ok    = (state_q == ST_INIT) || (hdr_sid_i == sid_q);
  assign seq_sum   = {1'b0, hdr_seq_i} + {{(SEQ_W+1-ML_W){1'b0}}, hdr_cnt_i};
  assign gap_dist  = hdr_seq_i - e_eff;
  assign retx_len  = (gap_dist > {{(SEQ_W-ML_W){1'b0}}, RETX_MAX}) ? RETX_MAX : gap_dist[ML_W-1:0];
  // Overlap skip is always < C, so modular low-bit subtraction is exact.
  assign skip_init = e_eff[ML_W-1:0] - hdr_seq_i[ML_W-1:0];
  assign retx_fire = retx_v_q && retx_ready_i;

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_INIT;
    else         state_q <= state_d;
  end

  // Next-state and header classification.
  always_comb begin
    state_d  = state_q;
    cls_drop = 1'b0;
    cls_gap  = 1'b0;
    case (state_q)
      ST_INIT, ST_IDLE: begin
        if (hdr_v_i) begin
          state_d = ST_IDLE;
          if (!sid_ok) begin
            state_d  = ST_DROP;
            cls_drop = 1'b1;
          end else if (&hdr_cnt_i) begin
            state_d = ST_END;
          end else if (hdr_cnt_i == '0) begin
            cls_gap = (hdr_seq_i > e_eff);
          end else if (hdr_seq_i == e_eff) begin
            state_d = ST_FWD;
          end else if (hdr_seq_i < e_eff) begin
            if (seq_sum <= {1'b0, e_eff}) begin
              state_d  = ST_DROP;
              cls_drop = 1'b1;
            end else begin
              state_d = ST_FWD;
            end
          end else begin
            state_d  = ST_DROP;
            cls_drop = 1'b1;
            cls_gap  = 1'b1;
          end
        end
      end
      ST_FWD, ST_DROP: if (pkt_end_i) state_d = ST_IDLE;
      default: state_d = ST_END;
    endcase
  end

  // Session, expected-sequence, skip and strobe registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sid_q    <= '0;
      locked_q <= 1'b0;
      exp_q    <= '0;
      seq_q    <= '0;
      cnt_q    <= '0;
      skip_q   <= '0;
      drop_q   <= 1'b0;
      perr_q   <= 1'b0;
      eos_q    <= 1'b0;
    end else begin
      drop_q <= cls_drop;
      perr_q <= hdr_v_i && ((state_q == ST_FWD) || (state_q == ST_DROP));
      eos_q  <= eos_q || (state_d == ST_END);
      if (hdr_v_i && (state_q == ST_INIT)) begin
        sid_q    <= hdr_sid_i;
        locked_q <= 1'b1;
        exp_q    <= hdr_seq_i;
      end else if ((state_q == ST_FWD) && pkt_end_i) begin
        exp_q <= seq_q + {{(SEQ_W-ML_W){1'b0}}, cnt_q};
      end
      if ((state_q != ST_FWD) && (state_d == ST_FWD)) begin
        seq_q  <= hdr_seq_i;
        cnt_q  <= hdr_cnt_i;
        skip_q <= skip_init;
      end else if ((state_q == ST_FWD) && msg_end_i && (skip_q != '0)) begin
        skip_q <= skip_q - 1'b1;
      end
    end
  end

  // Retransmission request: a pending request is never overwritten.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      retx_v_q   <= 1'b0;
      retx_seq_q <= '0;
      retx_cnt_q <= '0;
    end else if (cls_gap && (!retx_v_q || retx_fire)) begin
      retx_v_q   <= 1'b1;
      retx_seq_q <= e_eff;
      retx_cnt_q <= retx_len;
    end else if (retx_fire) begin
      retx_v_q <= 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    fwd_o        = (state_q == ST_FWD) && (skip_q == '0);
    drop_o       = drop_q;
    proto_err_o  = perr_q;
    eos_o        = eos_q;
    locked_o     = locked_q;
    expect_seq_o = exp_q;
    retx_v_o     = retx_v_q;
    retx_seq_o   = retx_seq_q;
    retx_cnt_o   = retx_cnt_q;
  end

endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Directed bench for mold_seq_ctrl.
module tb_mold_seq_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        hdr_v_i = 1'b0;
  logic [79:0] hdr_sid_i = '0;
  logic [63:0] hdr_seq_i = '0;
  logic [15:0] hdr_cnt_i = '0;
  logic        msg_end_i = 1'b0;
  logic        pkt_end_i = 1'b0;
  logic        retx_ready_i = 1'b0;
  logic        fwd_o, drop_o, retx_v_o, locked_o, eos_o, proto_err_o;
  logic [63:0] retx_seq_o, expect_seq_o;
  logic [15:0] retx_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [79:0] SID_A = 80'h4142_4344_4546_4748_494A;
  localparam logic [79:0] SID_B = 80'h5152_5354_5556_5758_595A;

  mold_seq_ctrl dut (
    .clk(clk), .nreset(nreset), .hdr_v_i(hdr_v_i), .hdr_sid_i(hdr_sid_i),
    .hdr_seq_i(hdr_seq_i), .hdr_cnt_i(hdr_cnt_i), .msg_end_i(msg_end_i),
    .pkt_end_i(pkt_end_i), .fwd_o(fwd_o), .drop_o(drop_o), .retx_v_o(retx_v_o),
    .retx_seq_o(retx_seq_o), .retx_cnt_o(retx_cnt_o), .retx_ready_i(retx_ready_i),
    .expect_seq_o(expect_seq_o), .locked_o(locked_o), .eos_o(eos_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    hdr_v_i = 1'b1; hdr_sid_i = sid; hdr_seq_i = seq; hdr_cnt_i = cnt;
    tick();
    hdr_v_i = 1'b0;
  endtask

  task automatic msg(input logic with_pkt_end);
    msg_end_i = 1'b1; pkt_end_i = with_pkt_end;
    tick();
    msg_end_i = 1'b0; pkt_end_i = 1'b0;
  endtask

  task automatic pkt();
    pkt_end_i = 1'b1;
    tick();
    pkt_end_i = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_fwd", fwd_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_expect", expect_seq_o, 0);
    chk("rst_retx_v", retx_v_o, 0);
    chk("rst_eos", eos_o, 0);
    chk("rst_drop", drop_o, 0);
    nreset = 1'b1;
    tick();

    // In-order first packet locks the session.
    hdr(SID_A, 100, 3);
    chk("t1_locked", locked_o, 1);
    chk("t1_expect_init", expect_seq_o, 100);
    for (int i = 0; i < 3; i++) begin
      chk("t1_fwd_msg", fwd_o, 1);
      msg(1'b0);
    end
    pkt();
    chk("t1_fwd_after", fwd_o, 0);
    chk("t1_expect", expect_seq_o, 103);

    // Overlap: skip two, forward two; last message ends with the packet.
    hdr(SID_A, 101, 4);
    chk("t2_drop", drop_o, 0);
    chk("t2_skip_m1", fwd_o, 0); msg(1'b0);
    chk("t2_skip_m2", fwd_o, 0); msg(1'b0);
    chk("t2_fwd_m3", fwd_o, 1); msg(1'b0);
    chk("t2_fwd_m4", fwd_o, 1); msg(1'b1);
    chk("t2_fwd_after", fwd_o, 0);
    chk("t2_expect", expect_seq_o, 105);

    // Duplicate packet, plus a header mid-packet flagged as protocol error.
    hdr(SID_A, 100, 5);
    chk("t3_drop", drop_o, 1);
    chk("t3_fwd", fwd_o, 0);
    hdr(SID_A, 105, 1);
    chk("t3_drop_pulse", drop_o, 0);
    chk("t3_perr", proto_err_o, 1);
    tick();
    chk("t3_perr_pulse", proto_err_o, 0);
    pkt();
    chk("t3_expect", expect_seq_o, 105);

    // Gap larger than the cap; ready held low.
    hdr(SID_A, 400, 2);
    chk("t4_drop", drop_o, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_retx_v", retx_v_o, 1);
      chk("t4_retx_seq", retx_seq_o, 105);
      chk("t4_retx_cnt", retx_cnt_o, 256);
      tick();
    end
    pkt();
    hdr(SID_A, 300, 1);
    chk("t4_drop2", drop_o, 1);
    chk("t4_keep_cnt", retx_cnt_o, 256);
    chk("t4_keep_seq", retx_seq_o, 105);
    pkt();
    chk("t4_expect", expect_seq_o, 105);
    retx_ready_i = 1'b1;
    tick();
    retx_ready_i = 1'b0;
    chk("t4_retx_clr", retx_v_o, 0);

    // Heartbeat gap, foreign session, end of session.
    hdr(SID_A, 110, 0);
    chk("t5_hb_drop", drop_o, 0);
    chk("t5_hb_retx_v", retx_v_o, 1);
    chk("t5_hb_seq", retx_seq_o, 105);
    chk("t5_hb_cnt", retx_cnt_o, 5);
    chk("t5_hb_expect", expect_seq_o, 105);
    retx_ready_i = 1'b1;
    tick();
    retx_ready_i = 1'b0;
    chk("t5_hb_clr", retx_v_o, 0);
    hdr(SID_B, 105, 1);
    chk("t5_sid_drop", drop_o, 1);
    pkt();
    hdr(SID_A, 0, 16'hFFFF);
    chk("t5_eos", eos_o, 1);
    chk("t5_eos_drop", drop_o, 0);
    hdr(SID_A, 105, 1);
    chk("t5_end_fwd", fwd_o, 0);
    chk("t5_end_perr", proto_err_o, 0);
    chk("t5_end_drop", drop_o, 0);
    chk("t5_end_eos", eos_o, 1);

    // Async reset mid-FWD with a request pending.
    nreset = 1'b0; tick(); nreset = 1'b1; tick();
    hdr(SID_A, 200, 1);
    msg(1'b1);
    chk("t6_expect", expect_seq_o, 201);
    hdr(SID_A, 210, 0);
    chk("t6_retx_cnt", retx_cnt_o, 9);
    hdr(SID_A, 201, 2);
    chk("t6_fwd", fwd_o, 1);
    chk("t6_retx_v", retx_v_o, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("t6_rst_fwd", fwd_o, 0);
    chk("t6_rst_retx", retx_v_o, 0);
    chk("t6_rst_locked", locked_o, 0);
    chk("t6_rst_expect", expect_seq_o, 0);
    tick();
    nreset = 1'b1;
    tick();
    hdr(SID_B, 7, 1);
    chk("t6_relock", locked_o, 1);
    chk("t6_relock_exp", expect_seq_o, 7);
    chk("t6_relock_fwd", fwd_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
